dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
//
// PURPOSE
//   Shares the single-port word-addressed data memory between two requesters:
//   - port 0: RISC-V core load/store
//   - port 1: comms/loader engine (UART/SPI DMA)
//   Grants one access at a time, sequences memory write-enable and address,
//   and returns read data plus an error flag to the winning port.
//   Port 0 has fixed priority; a starvation guard bounds port 1 wait time.
//
// PARAMETERS
//   DEPTH      64  data memory depth in 32-bit words (address range check)
//   MAX_CONSEC 4   max consecutive port-0 grants while port 1 waits
//
// PORTS
//   clk           in   1   system clock, all state on rising edge
//   rst_n         in   1   asynchronous active-low reset
//   pN_req_valid  in   1   port N (N=0,1) request valid
//   pN_req_ready  out  1   port N request accepted this cycle
//   pN_we         in   1   port N write (1) / read (0)
//   pN_addr       in   32  port N byte address
//   pN_wdata      in   32  port N write data
//   pN_rsp_valid  out  1   port N response pulse, one cycle
//   pN_rdata      out  32  port N read data, valid with pN_rsp_valid
//   pN_err        out  1   port N error (range/alignment), valid with rsp
//   mem_we        out  1   data memory write enable
//   mem_a         out  32  data memory byte address
//   mem_wd        out  32  data memory write data
//   mem_rd        in   32  data memory combinational read data
//
// BEHAVIOUR
//   - Reset: state=IDLE, starve_cnt=0, all outputs 0, latched regs 0.
//   - FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles.
//   - IDLE, grant choice (combinational):
//     - only one valid: that port wins
//     - both valid: port 0 wins, unless starve_cnt==MAX_CONSEC -> port 1
//     - pN_req_ready = (state==IDLE) && sel==N && pN_req_valid
//   - Handshake (valid&ready, cycle T):
//     - latch id, we, addr, wdata
//     - go to ACCESS
//   - starve_cnt:
//     - +1 when port 0 granted while p1_req_valid=1
//     - cleared when port 1 granted, or when p1_req_valid=0 at a grant
//     - saturates at MAX_CONSEC
//   - ACCESS (T+1):
//     - mem_a=latched addr
//     - mem_we = we & ok, where ok = (addr[31:2] < DEPTH) && (addr[1:0]==0)
//     - capture rdata = (!we && ok) ? mem_rd : 0; err = !ok
//     - go to RESP
//   - RESP (T+2):
//     - pN_rsp_valid=1 only for latched id, for exactly one cycle
//     - pN_rdata/pN_err hold until that port's next response
//     - go to IDLE; no new grant in this cycle
//   - mem_we is 1 only in ACCESS.
//     - mem_a/mem_wd always show latched values (glitch-free to memory).
//   - Requester holds valid and fields stable until ready.
//     - Dropping valid before ready is allowed; nothing is issued.
//   - Out-of-range or misaligned write: memory untouched, err=1.
//     - Out-of-range or misaligned read: rdata=0, err=1.
//   - Reset mid-operation: asynchronous return to IDLE.
//     - mem_we deasserts immediately; pending transaction dropped with no response.
//     - Requester reissues after reset.
//
// STRUCTURE
//   - Shared header dmem_arb_defs.vh:
//     - state encodings S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2
//     - port ids PORT_CORE=1'b0, PORT_DMA=1'b1
//   - Sub-module dmem_arb_prio: grant select plus starve_cnt counter.
//     - inputs: valids, idle, handshake
//     - outputs: sel
//   - Top: FSM, request latches, range check, response registers.
//
// TESTING
//   1. p0 write 0xDEADBEEF @0x8, then p0 read 0x8
//      -> read rsp_valid exactly 2 cycles after ready; rdata=0xDEADBEEF, err=0.
//   2. p0 and p1 valid every cycle, MAX_CONSEC=4
//      -> grant order 0,0,0,0,1,0,0,0,0,1; no port-1 wait beyond 5 grants.
//   3. p1 write 0x12345678 @0x100 (DEPTH=64)
//      -> mem_we never 1; p1_err=1; later read of 0x0 returns prior value.
//   4. p0 read @0x6 -> p0_err=1, p0_rdata=0, mem_we=0 throughout.
//   5. rst_n low during ACCESS of a write
//      -> mem_we=0 same cycle, no rsp_valid; after release state IDLE, cnt=0.
//   6. p1 valid alone in IDLE -> p1_req_ready same cycle; rsp 2 cycles later.
//      - p0 outputs untouched.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t   : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   PORT_CORE : port id of the core load/store requester
//   PORT_DMA  : port id of the comms/loader engine
//   addr_ok() : word-aligned and inside the memory depth
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;

   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   req_valid/req_ready : request handshake
//   we, addr, wdata     : request fields, stable while req_valid && !req_ready
//   rsp_valid           : one-cycle response pulse
//   rdata, err          : response data/error, held until the next response
// modport master : requester side; modport slave : arbiter side.
interface dmem_arbiter_if;
   logic        req_valid;
   logic        req_ready;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req_valid, we, addr, wdata,
      input  req_ready, rsp_valid, rdata, err
   );

   modport slave (
      input  req_valid, we, addr, wdata,
      output req_ready, rsp_valid, rdata, err
   );
endinterface

// File: rtl/dmem_arbiter_prio.sv
// Grant selection with a starvation guard for the DMA port.
//   clk, rst_n : clock, asynchronous active-low reset
//   v0, v1     : request valid of port 0 (core) / port 1 (DMA)
//   idle       : arbiter FSM is in IDLE
//   hs         : a request is being accepted this cycle
//   sel        : winning port id (combinational)
module dmem_arb_prio
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic v0,
   input  logic v1,
   input  logic idle,
   input  logic hs,
   output logic sel
);

   localparam int unsigned CW = $clog2(MAX_CONSEC + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

   // consecutive core grants taken while the DMA port was waiting
   logic [CW-1:0] starve_cnt;

   always_comb begin
      sel = PORT_CORE;
      if (v1 && (!v0 || starve_cnt == CNT_MAX))
         sel = PORT_DMA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (idle && hs) begin
         if (sel == PORT_DMA || !v1)
            starve_cnt <= '0;
         else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port word-addressed data memory.
// One transaction every three cycles: IDLE (grant) -> ACCESS -> RESP.
//   clk, rst_n : clock, asynchronous active-low reset
//   p0         : core load/store port (fixed priority)
//   p1         : comms/loader DMA port (starvation-guarded)
//   mem_we     : memory write enable, high only in ACCESS
//   mem_a      : memory byte address (latched request address)
//   mem_wd     : memory write data (latched request data)
//   mem_rd     : memory combinational read data
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_arbiter_if.slave       p0,
   dmem_arbiter_if.slave       p1,
   output logic                mem_we,
   output logic [31:0]         mem_a,
   output logic [31:0]         mem_wd,
   input  logic [31:0]         mem_rd
);

   state_t      state;
   logic        idle;
   logic        sel;
   logic        hs;
   logic        lat_id;
   logic        lat_we;
   logic        lat_ok;

   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ok;
   logic [31:0] rsp_rdata;

   assign idle = (state == S_IDLE);

   dmem_arb_prio #(
      .MAX_CONSEC (MAX_CONSEC)
   ) u_prio (
      .clk   (clk),
      .rst_n (rst_n),
      .v0    (p0.req_valid),
      .v1    (p1.req_valid),
      .idle  (idle),
      .hs    (hs),
      .sel   (sel)
   );

   assign p0.req_ready = idle && (sel == PORT_CORE) && p0.req_valid;
   assign p1.req_ready = idle && (sel == PORT_DMA)  && p1.req_valid;
   assign hs           = p0.req_ready || p1.req_ready;

   always_comb begin
      req_we    = p0.we;
      req_addr  = p0.addr;
      req_wdata = p0.wdata;
      if (sel == PORT_DMA) begin
         req_we    = p1.we;
         req_addr  = p1.addr;
         req_wdata = p1.wdata;
      end
      req_ok = addr_ok(req_addr, DEPTH);
   end

   assign rsp_rdata = (!lat_we && lat_ok) ? mem_rd : '0;

   // mem_we is registered at the grant so it is high for exactly the ACCESS
   // cycle; mem_a/mem_wd double as the latched address/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         lat_id       <= PORT_CORE;
         lat_we       <= 1'b0;
         lat_ok       <= 1'b0;
         mem_we       <= 1'b0;
         mem_a        <= '0;
         mem_wd       <= '0;
         p0.rsp_valid <= 1'b0;
         p0.rdata     <= '0;
         p0.err       <= 1'b0;
         p1.rsp_valid <= 1'b0;
         p1.rdata     <= '0;
         p1.err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hs) begin
                  lat_id <= sel;
                  lat_we <= req_we;
                  lat_ok <= req_ok;
                  mem_a  <= req_addr;
                  mem_wd <= req_wdata;
                  mem_we <= req_we && req_ok;
                  state  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               mem_we <= 1'b0;
               if (lat_id == PORT_DMA) begin
                  p1.rsp_valid <= 1'b1;
                  p1.rdata     <= rsp_rdata;
                  p1.err       <= !lat_ok;
               end else begin
                  p0.rsp_valid <= 1'b1;
                  p0.rdata     <= rsp_rdata;
                  p0.err       <= !lat_ok;
               end
               state <= S_RESP;
            end
            S_RESP: begin
               p0.rsp_valid <= 1'b0;
               p1.rsp_valid <= 1'b0;
               state        <= S_IDLE;
            end
            default: begin
               mem_we <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a
// behavioural 64-word memory.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   always #5 clk = ~clk;

   dmem_arbiter_if p0();
   dmem_arbiter_if p1();

   dmem_arbiter #(
      .DEPTH      (DEPTH),
      .MAX_CONSEC (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .p0     (p0),
      .p1     (p1),
      .mem_we (mem_we),
      .mem_a  (mem_a),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
   );

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model of one accepted request; rsp due two cycles after grant
   function automatic exp_t model(input bit port, input bit we,
                                  input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      logic ok;
      ok = addr_ok(addr, DEPTH);
      if (we && ok) ref_mem[addr[7:2]] = wdata;
      e.port  = port;
      e.rdata = (!we && ok) ? ref_mem[addr[7:2]] : 32'h0;
      e.err   = !ok;
      e.cyc   = cyc + 2;
      return e;
   endfunction

   function automatic logic rdy(input bit port);
      return port ? p1.req_ready : p0.req_ready;
   endfunction

   task automatic set_req(input bit port, input bit v, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
      if (port) begin
         p1.req_valid = v; p1.we = we; p1.addr = a; p1.wdata = d;
      end else begin
         p0.req_valid = v; p0.we = we; p0.addr = a; p0.wdata = d;
      end
   endtask

   task automatic do_req(input bit port, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit immediate);
      int  waited;
      bit  got;
      waited = 0;
      got    = 0;
      @(posedge clk); #1;
      set_req(port, 1'b1, we, a, d);
      while (!got && waited < 20) begin
         @(negedge clk);
         if (rdy(port) === 1'b1) got = 1;
         else waited++;
      end
      chk("ready_timeout", 32'(got), 32'd1);
      if (got) begin
         sb.push_back(model(port, we, a, d));
         if (immediate) chk("ready_same_cycle", 32'(waited), 32'd0);
      end
      @(posedge clk); #1;
      set_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // response monitor / scoreboard checker
   always @(negedge clk) begin
      exp_t e;
      if (p0.rsp_valid === 1'b1 || p1.rsp_valid === 1'b1) begin
         chk("rsp_exclusive", 32'(p0.rsp_valid & p1.rsp_valid), 32'd0);
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_port",  32'(p1.rsp_valid), 32'(e.port));
            chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            if (e.port) begin
               chk("p1_rdata", p1.rdata, e.rdata);
               chk("p1_err",   32'(p1.err), 32'(e.err));
            end else begin
               chk("p0_rdata", p0.rdata, e.rdata);
               chk("p0_err",   32'(p0.err), 32'(e.err));
            end
         end
      end
      if (mem_we === 1'b1)
         chk("mem_we_legal_addr", 32'(addr_ok(mem_a, DEPTH)), 32'd1);
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int order [10];
      int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int n;
      int w;
      bit got;

      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'h0BAD_0000 | i;
         ref_mem[i] = 32'h0BAD_0000 | i;
      end
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

      // reset state
      #12;
      chk("rst_mem_we",    32'(mem_we), 32'd0);
      chk("rst_mem_a",     mem_a,  32'h0);
      chk("rst_mem_wd",    mem_wd, 32'h0);
      chk("rst_p0_rsp",    32'(p0.rsp_valid), 32'd0);
      chk("rst_p1_rsp",    32'(p1.rsp_valid), 32'd0);
      chk("rst_p0_rdata",  p0.rdata, 32'h0);
      chk("rst_p1_err",    32'(p1.err), 32'd0);
      chk("rst_state",     32'(dut.state), 32'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // 1: write then read back on port 0
      do_req(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1);
      drain();
      do_req(1'b0, 1'b0, 32'h8, 32'h0, 1'b1);
      drain();
      chk("t1_p0_rdata", p0.rdata, 32'hDEAD_BEEF);

      // 3: out-of-range DMA write leaves memory untouched
      do_req(1'b0, 1'b1, 32'h0, 32'hA5A5_0000, 1'b1);
      drain();
      do_req(1'b1, 1'b1, 32'h100, 32'h1234_5678, 1'b1);
      drain();
      chk("t3_p1_err", 32'(p1.err), 32'd1);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      drain();
      chk("t3_p1_rdata", p1.rdata, 32'hA5A5_0000);

      // 4: misaligned read
      do_req(1'b0, 1'b0, 32'h6, 32'h0, 1'b1);
      drain();
      chk("t4_p0_err",   32'(p0.err), 32'd1);
      chk("t4_p0_rdata", p0.rdata, 32'h0);

      // 6: lone DMA read, port 0 outputs keep their last response
      do_req(1'b1, 1'b0, 32'h14, 32'h0, 1'b1);
      drain();
      chk("t6_p1_rdata", p1.rdata, 32'h0BAD_0005);
      chk("t6_p0_rdata_held", p0.rdata, 32'h0);
      chk("t6_p0_err_held",   32'(p0.err), 32'd1);

      // 2: both ports requesting continuously
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      set_req(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
      n = 0;
      w = 0;
      while (n < 10 && w < 100) begin
         @(negedge clk);
         w++;
         if (p0.req_ready === 1'b1) begin
            sb.push_back(model(1'b0, 1'b0, 32'h10, 32'h0));
            order[n] = 0;
            n++;
         end else if (p1.req_ready === 1'b1) begin
            sb.push_back(model(1'b1, 1'b0, 32'h14, 32'h0));
            order[n] = 1;
            n++;
         end
      end
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_grant_count", 32'(n), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < n) chk("t2_grant_order", 32'(order[i]), 32'(exp_order[i]));
      drain();

      // 5: reset while a write is in ACCESS
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
      set_req(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
      got = 0;
      w = 0;
      while (!got && w < 20) begin
         @(negedge clk);
         if (p0.req_ready === 1'b1) got = 1;
         else w++;
      end
      chk("t5_ready", 32'(got), 32'd1);
      @(posedge clk); #1;
      chk("t5_mem_we_access", 32'(mem_we), 32'd1);
      chk("t5_cnt_before",    32'(dut.u_prio.starve_cnt), 32'd1);
      #2;
      rst_n = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("t5_mem_we_async", 32'(mem_we), 32'd0);
      chk("t5_state_async",  32'(dut.state), 32'(S_IDLE));
      repeat (3) @(posedge clk);
      #1;
      chk("t5_p0_rsp", 32'(p0.rsp_valid), 32'd0);
      chk("t5_p1_rsp", 32'(p1.rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_state_after", 32'(dut.state), 32'(S_IDLE));
      chk("t5_cnt_after",   32'(dut.u_prio.starve_cnt), 32'd0);
      do_req(1'b0, 1'b0, 32'h20, 32'h0, 1'b1);
      drain();
      chk("t5_mem_untouched", p0.rdata, 32'h0BAD_0008);

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
